// File: rtl/uart_rx_fifo_if.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo_if
// Receive-stream handshake between the UART receiver FIFO and its consumer.
//   m_valid      : head entry available (receiver -> consumer)
//   m_ready      : consumer accepts head entry (consumer -> receiver)
//   m_data       : head entry data, LSB = first bit received
//   m_parity_err : head entry parity mismatch
//   m_frame_err  : head entry had a low stop bit
// Modports: master = receiver side, slave = consumer side.
// ---------------------------------------------------------------------------
interface uart_rx_fifo_if #(
   parameter int DATA_BITS = 8
);
   logic                 m_valid;
   logic                 m_ready;
   logic [DATA_BITS-1:0] m_data;
   logic                 m_parity_err;
   logic                 m_frame_err;

   modport master (
      output m_valid, m_data, m_parity_err, m_frame_err,
      input  m_ready
   );

   modport slave (
      input  m_valid, m_data, m_parity_err, m_frame_err,
      output m_ready
   );
endinterface

// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo
// UART receiver (start/data/optional parity/stop) feeding a small FIFO.
// Ports:
//   clk      : clock, rising edge
//   rst_n    : asynchronous active-low reset
//   rx       : asynchronous serial line, idles high
//   m        : receive stream (uart_rx_fifo_if.master)
//   overrun  : one-cycle pulse when a completed frame is dropped (FIFO full)
//   busy     : receiver FSM not idle
// ---------------------------------------------------------------------------
module uart_rx_fifo #(
   parameter int CLKS_PER_BIT = 434,
   parameter int DATA_BITS    = 8,
   parameter int PARITY_MODE  = 0,
   parameter int STOP_BITS    = 1,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           rx,
   uart_rx_fifo_if.master m,
   output logic           overrun,
   output logic           busy
);
   localparam int          AW        = $clog2(FIFO_DEPTH);
   localparam int          EW        = DATA_BITS + 2;
   localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
   localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);
   localparam logic [3:0]  DATA_LAST = 4'(DATA_BITS - 1);
   localparam logic        STOP_LAST = 1'(STOP_BITS - 1);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_START  = 3'd1;
   localparam logic [2:0] S_DATA   = 3'd2;
   localparam logic [2:0] S_PARITY = 3'd3;
   localparam logic [2:0] S_STOP   = 3'd4;
   localparam logic [2:0] S_BRK    = 3'd5;

   logic                 sync1_q, rs_q, rs_prev_q, rs_prev_d;
   logic [1:0]           fill_q, fill_d;
   logic [2:0]           state_q, state_d;
   logic [15:0]          timer_q, timer_d;
   logic [3:0]           bit_cnt_q, bit_cnt_d;
   logic                 stop_cnt_q, stop_cnt_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 perr_q, perr_d, ferr_q, ferr_d;
   logic                 done_q, done_d, stop_low_q, stop_low_d;
   logic                 overrun_q, overrun_d;
   logic [AW:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [EW-1:0]        mem_q [FIFO_DEPTH];
   logic                 push, push_ok, pop, full, empty, sample, par;
   logic [EW-1:0]        head;

   // rs_prev only becomes 1 once the synchronizer holds real line values, so
   // a line held low through reset release is not mistaken for a start edge.
   always_comb begin
      fill_d    = {fill_q[0], 1'b1};
      rs_prev_d = rs_q & fill_q[1];
   end

   // Receiver FSM; every state change clears the bit timer.
   always_comb begin
      state_d    = state_q;
      timer_d    = timer_q + 16'd1;
      bit_cnt_d  = bit_cnt_q;
      stop_cnt_d = stop_cnt_q;
      shift_d    = shift_q;
      perr_d     = perr_q;
      ferr_d     = ferr_q;
      done_d     = done_q;
      stop_low_d = stop_low_q;
      push       = 1'b0;
      sample     = (timer_q == BIT_LAST);
      par        = (^shift_q) ^ rs_q;
      case (state_q)
         S_IDLE: begin
            timer_d = '0;
            if (rs_prev_q && !rs_q) state_d = S_START;
         end
         S_START: begin
            if (timer_q == HALF_LAST) begin
               timer_d = '0;
               if (!rs_q) begin
                  state_d   = S_DATA;
                  bit_cnt_d = '0;
                  perr_d    = 1'b0;
                  ferr_d    = 1'b0;
                  done_d    = 1'b0;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         S_DATA: begin
            if (sample) begin
               timer_d   = '0;
               shift_d   = {rs_q, shift_q[DATA_BITS-1:1]};
               bit_cnt_d = bit_cnt_q + 4'd1;
               if (bit_cnt_q == DATA_LAST) begin
                  state_d    = (PARITY_MODE != 0) ? S_PARITY : S_STOP;
                  stop_cnt_d = 1'b0;
               end
            end
         end
         S_PARITY: begin
            if (sample) begin
               timer_d    = '0;
               state_d    = S_STOP;
               stop_cnt_d = 1'b0;
               perr_d     = (PARITY_MODE == 2) ? ~par : par;
            end
         end
         S_STOP: begin
            // The frame is pushed one cycle after the final stop sample.
            if (done_q) begin
               push    = 1'b1;
               done_d  = 1'b0;
               timer_d = '0;
               state_d = stop_low_q ? S_BRK : S_IDLE;
            end else if (sample) begin
               timer_d    = '0;
               stop_cnt_d = stop_cnt_q + 1'b1;
               if (!rs_q) ferr_d = 1'b1;
               if (stop_cnt_q == STOP_LAST) begin
                  done_d     = 1'b1;
                  stop_low_d = ~rs_q;
               end
            end
         end
         S_BRK: begin
            timer_d = '0;
            if (rs_q) state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
            timer_d = '0;
         end
      endcase
   end

   // FIFO bookkeeping: pointers carry one extra wrap bit.
   always_comb begin
      empty     = (wr_ptr_q == rd_ptr_q);
      full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
      pop       = !empty && m.m_ready;
      push_ok   = push && (!full || pop);
      overrun_d = push && full && !pop;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q    <= 1'b1;
         rs_q       <= 1'b1;
         rs_prev_q  <= 1'b0;
         fill_q     <= '0;
         state_q    <= S_IDLE;
         timer_q    <= '0;
         bit_cnt_q  <= '0;
         stop_cnt_q <= 1'b0;
         shift_q    <= '0;
         perr_q     <= 1'b0;
         ferr_q     <= 1'b0;
         done_q     <= 1'b0;
         stop_low_q <= 1'b0;
         overrun_q  <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
      end else begin
         sync1_q    <= rx;
         rs_q       <= sync1_q;
         rs_prev_q  <= rs_prev_d;
         fill_q     <= fill_d;
         state_q    <= state_d;
         timer_q    <= timer_d;
         bit_cnt_q  <= bit_cnt_d;
         stop_cnt_q <= stop_cnt_d;
         shift_q    <= shift_d;
         perr_q     <= perr_d;
         ferr_q     <= ferr_d;
         done_q     <= done_d;
         stop_low_q <= stop_low_d;
         overrun_q  <= overrun_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= {perr_q, ferr_q, shift_q};
   end

   assign head           = mem_q[rd_ptr_q[AW-1:0]];
   assign m.m_valid      = !empty;
   assign m.m_data       = empty ? '0 : head[DATA_BITS-1:0];
   assign m.m_frame_err  = empty ? 1'b0 : head[EW-2];
   assign m.m_parity_err = empty ? 1'b0 : head[EW-1];
   assign overrun        = overrun_q;
   assign busy           = (state_q != S_IDLE);
endmodule

// File: tb/tb_uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_fifo
// Two receivers share clk/rst_n: unit A is 8N1, unit B is 8E2; both have a
// 4-entry FIFO and 16 clocks per bit. Frames are modelled at frame level:
// each sent frame yields {parity_err, frame_err, data} or an overrun.
// ---------------------------------------------------------------------------
module tb_uart_rx_fifo;
   localparam int CPB   = 16;
   localparam int DEPTH = 4;

   logic clk = 1'b0;
   logic rst_n, rx_a, rx_b, ready_a, ready_b;
   logic ov_a, ov_b, busy_a, busy_b;
   int   n_cmp = 0, n_fail = 0;

   logic [9:0] got_a[$], got_b[$], exp_a[$], exp_b[$];
   int         ov_cnt_a = 0, exp_ov_a = 0;

   always #5 clk = ~clk;

   uart_rx_fifo_if #(.DATA_BITS(8)) ifa ();
   uart_rx_fifo_if #(.DATA_BITS(8)) ifb ();
   assign ifa.m_ready = ready_a;
   assign ifb.m_ready = ready_b;

   uart_rx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(0),
                  .STOP_BITS(1), .FIFO_DEPTH(DEPTH))
      u_a (.clk(clk), .rst_n(rst_n), .rx(rx_a), .m(ifa), .overrun(ov_a), .busy(busy_a));

   uart_rx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(1),
                  .STOP_BITS(2), .FIFO_DEPTH(DEPTH))
      u_b (.clk(clk), .rst_n(rst_n), .rx(rx_b), .m(ifb), .overrun(ov_b), .busy(busy_b));

   // Record every accepted entry and every overrun pulse.
   always @(negedge clk) begin
      if (rst_n) begin
         if (ifa.m_valid && ifa.m_ready)
            got_a.push_back({ifa.m_parity_err, ifa.m_frame_err, ifa.m_data});
         if (ifb.m_valid && ifb.m_ready)
            got_b.push_back({ifb.m_parity_err, ifb.m_frame_err, ifb.m_data});
         if (ov_a) ov_cnt_a++;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic set_rx(input int ch, input logic v);
      if (ch == 0) rx_a = v;
      else         rx_b = v;
   endtask

   task automatic clear_q();
      got_a.delete(); got_b.delete(); exp_a.delete(); exp_b.delete();
      ov_cnt_a = 0; exp_ov_a = 0;
   endtask

   // Sends one frame; ch 0 = 8N1 (s1 is its stop bit), ch 1 = 8E2.
   task automatic send(input int ch, input logic [7:0] d, input logic pbit,
                       input logic s0, input logic s1);
      logic [9:0] e;
      set_rx(ch, 1'b0);
      wait_cyc(CPB);
      for (int i = 0; i < 8; i++) begin
         set_rx(ch, d[i]);
         wait_cyc(CPB);
      end
      if (ch == 1) begin
         set_rx(ch, pbit); wait_cyc(CPB);
         set_rx(ch, s0);   wait_cyc(CPB);
      end
      set_rx(ch, s1);
      if (ch == 0) begin
         e = {1'b0, ~s1, d};
         if (exp_a.size() - got_a.size() < DEPTH) exp_a.push_back(e);
         else exp_ov_a++;
      end else begin
         e = {(^d) ^ pbit, ~(s0 & s1), d};
         if (exp_b.size() - got_b.size() < DEPTH) exp_b.push_back(e);
      end
      wait_cyc(CPB);
      set_rx(ch, 1'b1);
      wait_cyc(2 * CPB);
   endtask

   task automatic test_reset();
      logic [12:0] obs;
      repeat (3) @(negedge clk);
      obs = {ifa.m_valid, ifa.m_data, ifa.m_parity_err, ifa.m_frame_err, ov_a, busy_a};
      n_cmp++;
      if (obs !== 13'h0) begin n_fail++; $display("FAIL reset_a: got %h expected 0", obs); end
      obs = {ifb.m_valid, ifb.m_data, ifb.m_parity_err, ifb.m_frame_err, ov_b, busy_b};
      n_cmp++;
      if (obs !== 13'h0) begin n_fail++; $display("FAIL reset_b: got %h expected 0", obs); end
      wait_cyc(1);
      rst_n = 1'b1;
      wait_cyc(5);
      n_cmp++;
      if ({busy_a, busy_b, ifa.m_valid, ifb.m_valid} !== 4'b0) begin
         n_fail++; $display("FAIL post_reset_idle: got %b expected 0000",
                            {busy_a, busy_b, ifa.m_valid, ifb.m_valid});
      end
   endtask

   task automatic test_basic();
      clear_q();
      ready_a = 1'b1;
      send(0, 8'hA5, 1'b0, 1'b1, 1'b1);
      n_cmp++;
      if (got_a.size() !== 1) begin n_fail++; $display("FAIL basic_count: got %0d expected 1", got_a.size()); end
      n_cmp++;
      if (got_a.size() > 0 && got_a[0] !== 10'h0A5) begin
         n_fail++; $display("FAIL basic_entry: got %h expected 0a5", got_a[0]);
      end
   endtask

   task automatic test_random_a();
      logic [7:0] d;
      logic       s;
      clear_q();
      ready_a = 1'b1;
      for (int i = 0; i < 8; i++) begin
         d = 8'($urandom_range(0, 255));
         s = ($urandom_range(0, 3) != 0);
         send(0, d, 1'b0, 1'b1, s);
      end
      n_cmp++;
      if (got_a.size() !== exp_a.size()) begin
         n_fail++; $display("FAIL rand_a_count: got %0d expected %0d", got_a.size(), exp_a.size());
      end
      for (int i = 0; i < exp_a.size() && i < got_a.size(); i++) begin
         n_cmp++;
         if (got_a[i] !== exp_a[i]) begin
            n_fail++; $display("FAIL rand_a_entry%0d: got %h expected %h", i, got_a[i], exp_a[i]);
         end
      end
   endtask

   task automatic test_parity();
      logic [7:0] d;
      logic       p;
      clear_q();
      ready_b = 1'b1;
      send(1, 8'h03, 1'b1, 1'b1, 1'b1);
      send(1, 8'h03, 1'b0, 1'b1, 1'b1);
      n_cmp++;
      if (got_b.size() < 2 || got_b[0] !== 10'h203 || got_b[1] !== 10'h003) begin
         n_fail++; $display("FAIL parity_fixed: got %0d entries (%h %h) expected 203 003",
                            got_b.size(), got_b.size() > 0 ? got_b[0] : 10'h3ff,
                            got_b.size() > 1 ? got_b[1] : 10'h3ff);
      end
      for (int i = 0; i < 6; i++) begin
         d = 8'($urandom_range(0, 255));
         p = 1'($urandom_range(0, 1));
         send(1, d, p, 1'b1, 1'b1);
      end
      n_cmp++;
      if (got_b.size() !== exp_b.size()) begin
         n_fail++; $display("FAIL parity_count: got %0d expected %0d", got_b.size(), exp_b.size());
      end
      for (int i = 0; i < exp_b.size() && i < got_b.size(); i++) begin
         n_cmp++;
         if (got_b[i] !== exp_b[i]) begin
            n_fail++; $display("FAIL parity_entry%0d: got %h expected %h", i, got_b[i], exp_b[i]);
         end
      end
   endtask

   task automatic test_stop2();
      clear_q();
      ready_b = 1'b1;
      send(1, 8'hC3, 1'b0, 1'b1, 1'b0);
      send(1, 8'h3C, 1'b0, 1'b0, 1'b1);
      n_cmp++;
      if (got_b.size() !== 2) begin n_fail++; $display("FAIL stop2_count: got %0d expected 2", got_b.size()); end
      for (int i = 0; i < 2 && i < got_b.size(); i++) begin
         n_cmp++;
         if (got_b[i] !== exp_b[i] || got_b[i][8] !== 1'b1) begin
            n_fail++; $display("FAIL stop2_entry%0d: got %h expected %h", i, got_b[i], exp_b[i]);
         end
      end
   endtask

   task automatic test_glitch();
      logic seen = 1'b0;
      clear_q();
      rx_a = 1'b0;
      for (int i = 0; i < 5; i++) begin
         wait_cyc(1);
         if (busy_a) seen = 1'b1;
      end
      rx_a = 1'b1;
      for (int i = 0; i < 20; i++) begin
         wait_cyc(1);
         if (busy_a) seen = 1'b1;
      end
      wait_cyc(2 * CPB);
      n_cmp++;
      if (seen !== 1'b1) begin n_fail++; $display("FAIL glitch_busy_pulse: got %b expected 1", seen); end
      n_cmp++;
      if (busy_a !== 1'b0 || got_a.size() !== 0) begin
         n_fail++; $display("FAIL glitch_reject: busy %b entries %0d expected 0 0", busy_a, got_a.size());
      end
   endtask

   task automatic test_break();
      clear_q();
      ready_a = 1'b1;
      rx_a = 1'b0;
      exp_a.push_back({1'b0, 1'b1, 8'h00});
      wait_cyc(20 * CPB);
      n_cmp++;
      if (got_a.size() !== 1 || got_a[0] !== exp_a[0]) begin
         n_fail++; $display("FAIL break_entry: got %0d entries first %h expected 1 entry %h",
                            got_a.size(), got_a.size() > 0 ? got_a[0] : 10'h3ff, exp_a[0]);
      end
      rx_a = 1'b1;
      wait_cyc(2 * CPB);
      n_cmp++;
      if (busy_a !== 1'b0 || got_a.size() !== 1) begin
         n_fail++; $display("FAIL break_release: busy %b entries %0d expected 0 1", busy_a, got_a.size());
      end
      send(0, 8'h5A, 1'b0, 1'b1, 1'b1);
      n_cmp++;
      if (got_a.size() !== 2 || got_a[1] !== 10'h05A) begin
         n_fail++; $display("FAIL break_next_frame: got %0d entries expected 2 with 05a", got_a.size());
      end
   endtask

   task automatic test_overrun();
      logic [10:0] hold0, hold;
      clear_q();
      ready_a = 1'b0;
      for (int i = 1; i <= 4; i++) send(0, 8'(i), 1'b0, 1'b1, 1'b1);
      n_cmp++;
      if (ov_cnt_a !== 0) begin n_fail++; $display("FAIL overrun_early: got %0d expected 0", ov_cnt_a); end
      send(0, 8'h05, 1'b0, 1'b1, 1'b1);
      n_cmp++;
      if (ov_cnt_a !== exp_ov_a) begin
         n_fail++; $display("FAIL overrun_count: got %0d expected %0d", ov_cnt_a, exp_ov_a);
      end
      @(negedge clk);
      hold0 = {ifa.m_valid, ifa.m_parity_err, ifa.m_frame_err, ifa.m_data};
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         hold = {ifa.m_valid, ifa.m_parity_err, ifa.m_frame_err, ifa.m_data};
         n_cmp++;
         if (hold !== {1'b1, exp_a[0]}) begin
            n_fail++; $display("FAIL hold_stable%0d: got %h expected %h (first %h)", i, hold, {1'b1, exp_a[0]}, hold0);
         end
      end
      wait_cyc(1);
      ready_a = 1'b1;
      wait_cyc(10);
      n_cmp++;
      if (got_a.size() !== exp_a.size()) begin
         n_fail++; $display("FAIL drain_count: got %0d expected %0d", got_a.size(), exp_a.size());
      end
      for (int i = 0; i < exp_a.size() && i < got_a.size(); i++) begin
         n_cmp++;
         if (got_a[i] !== exp_a[i]) begin
            n_fail++; $display("FAIL drain_entry%0d: got %h expected %h", i, got_a[i], exp_a[i]);
         end
      end
   endtask

   task automatic test_reset_mid();
      clear_q();
      ready_a = 1'b0;
      send(0, 8'h11, 1'b0, 1'b1, 1'b1);
      rx_a = 1'b0;
      wait_cyc(CPB + 3 * CPB);
      rst_n = 1'b0;
      @(negedge clk);
      n_cmp++;
      if ({ifa.m_valid, busy_a} !== 2'b00) begin
         n_fail++; $display("FAIL reset_mid: valid/busy got %b expected 00", {ifa.m_valid, busy_a});
      end
      rx_a = 1'b1;
      wait_cyc(2);
      rst_n = 1'b1;
      clear_q();
      ready_a = 1'b1;
      wait_cyc(3 * CPB);
      n_cmp++;
      if (got_a.size() !== 0) begin n_fail++; $display("FAIL reset_discard: got %0d entries expected 0", got_a.size()); end
      // Line held low across reset release must not start a frame.
      rst_n = 1'b0;
      rx_a  = 1'b0;
      wait_cyc(3);
      rst_n = 1'b1;
      wait_cyc(3 * CPB);
      n_cmp++;
      if (busy_a !== 1'b0 || got_a.size() !== 0) begin
         n_fail++; $display("FAIL low_after_reset: busy %b entries %0d expected 0 0", busy_a, got_a.size());
      end
      rx_a = 1'b1;
      wait_cyc(2 * CPB);
      send(0, 8'h3C, 1'b0, 1'b1, 1'b1);
      n_cmp++;
      if (got_a.size() !== 1 || got_a[0] !== exp_a[0]) begin
         n_fail++; $display("FAIL first_after_low: got %0d entries expected 1 entry %h", got_a.size(), exp_a[0]);
      end
   endtask

   initial begin
      rst_n   = 1'b1;
      rx_a    = 1'b1;
      rx_b    = 1'b1;
      ready_a = 1'b0;
      ready_b = 1'b0;
      #3 rst_n = 1'b0;
      test_reset();
      test_basic();
      test_random_a();
      test_parity();
      test_stop2();
      test_glitch();
      test_break();
      test_overrun();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434: clk cycles per bit; legal 4..65535.
REQ-002 Parameter DATA_BITS, default 8: data bits per frame; legal 5..9.
REQ-003 Parameter PARITY_MODE, default 0: 0 none, 1 even, 2 odd.
REQ-004 Parameter STOP_BITS, default 1: legal values 1 or 2.
REQ-005 Parameter FIFO_DEPTH, default 4: receive FIFO entries; power of two, 2..64.
REQ-006 clk  input  1  clock; all logic on the rising edge.
REQ-007 rst_n  input  1  reset, asynchronous, active-low.
REQ-008 rx  input  1  asynchronous serial line; idles high.
REQ-009 m_valid  output  1  FIFO head entry is available.
REQ-010 m_ready  input  1  consumer accepts the head entry when m_valid is high.
REQ-011 m_data  output  DATA_BITS  head entry data, LSB = first received bit.
REQ-012 m_parity_err  output  1  head entry parity mismatch; always 0 when PARITY_MODE=0.
REQ-013 m_frame_err  output  1  head entry had at least one stop bit sampled low.
REQ-014 overrun  output  1  one-cycle pulse when a completed frame is dropped because the FIFO is full.
REQ-015 busy  output  1  high whenever the receiver FSM is not in IDLE.

Function
REQ-016 rx SHALL pass through a 2-flop synchronizer (reset value 1); all FSM logic SHALL use the synchronized value rs.
REQ-017 FSM states SHALL be IDLE, START, DATA, PARITY, STOP, BRK_WAIT.
REQ-018 IDLE: a high-to-low edge on rs SHALL enter START and clear the bit-timer.
REQ-019 START: at timer = CLKS_PER_BIT/2 - 1 (mid start bit), rs=0 SHALL enter DATA and rs=1 SHALL return to IDLE with nothing pushed (glitch rejection).
REQ-020 DATA: rs SHALL be sampled every CLKS_PER_BIT cycles after the mid-start sample, DATA_BITS samples, LSB first; after the last sample, enter PARITY if PARITY_MODE!=0, else STOP.
REQ-021 PARITY: one sample; parity error = (XOR of data bits XOR sample) != 0 for even, == 0 for odd.
REQ-022 STOP: STOP_BITS samples; any low sample SHALL set the frame error.
REQ-023 The frame (data, parity_err, frame_err) SHALL be pushed on the cycle after the final stop sample.
REQ-024 After the push, the FSM SHALL enter IDLE if the final stop sample was 1, else BRK_WAIT; BRK_WAIT SHALL go to IDLE on the first cycle rs=1, so that no new start is detected during a break.
REQ-025 Push with FIFO full and no simultaneous pop SHALL drop the new frame, keep the FIFO unchanged and pulse overrun for exactly one cycle.
REQ-026 Push and pop in the same cycle with the FIFO full SHALL both succeed, with occupancy unchanged and no overrun.
REQ-027 Pop SHALL occur when m_valid and m_ready are both high; m_data and the flags SHALL advance to the next entry on the following cycle.
REQ-028 m_valid SHALL rise on the cycle after a push into an empty FIFO (push-to-valid latency 1 cycle).
REQ-029 m_ready while m_valid=0 SHALL have no effect.
REQ-030 Outputs SHALL hold stable while m_valid=1 and m_ready=0.
REQ-031 FIFO pointers SHALL be log2(FIFO_DEPTH)+1 bits wide and wrap modulo 2*FIFO_DEPTH; full and empty SHALL derive from the MSB and the remaining bits.
REQ-032 Bit-timer SHALL be 16 bits wide and SHALL be cleared at every state transition.

Reset
REQ-033 While rst_n=0: FSM=IDLE, synchronizer flops=1, FIFO empty, m_valid=0, m_data=0, m_parity_err=0, m_frame_err=0, overrun=0, busy=0.
REQ-034 Reset asserted mid-frame SHALL discard the partial frame and the FIFO contents.
REQ-035 After reset release with rx held low, no frame SHALL be received until rs has been seen high and a new falling edge occurs.

Verification
REQ-036 CLKS_PER_BIT=16, 8N1; send 0xA5; m_ready=1 -> exactly one m_valid pulse with m_data=0xA5, both error flags 0.
REQ-037 PARITY_MODE=1; send 0x03 with parity bit 1 -> m_data=0x03, m_parity_err=1; repeat with parity bit 0 -> m_parity_err=0.
REQ-038 Low pulse of 5 cycles on rx -> busy pulses, no push, FSM returns to IDLE.
REQ-039 rx held low for 20 bit times -> one entry with m_data=0x00 and m_frame_err=1; no second frame until rx goes high and then falls again.
REQ-040 FIFO_DEPTH=4, m_ready=0, send 5 frames 0x01..0x05 -> overrun pulses once, on the 5th frame; draining yields 0x01..0x04 in order.
REQ-041 STOP_BITS=2; second stop bit low -> m_frame_err=1; reset asserted mid-DATA -> m_valid=0 and busy=0 on the next cycle.
